// File: rtl/hybrid_sequencer.sv
// Purpose : Sample-phase sequencer for a hybrid modulator front end. Tracks the
//           recursion phase and the frame position of each input sample, then
//           gates the recursion and output paths through FILL -> WARM -> RUN.
// Latency : recurse_en/ds_en pulse one cycle after the accepted sample;
//           state/compute_en/valid change in the cycle ds_en is high.
// Backpressure: none; every in_valid cycle is consumed, and counters hold while
//           in_valid is low.
//
// Ports:
//   clk, rst (async active-low, release synchronized internally), in_valid,
//   flush (present only when SEQ_FLUSH_EN is defined),
//   osr_count1, osr_count2, in_sel, recurse_en, ds_en, compute_en, valid, state.
// Build option: define SEQ_FLUSH_EN to add the synchronous flush input.
module hybrid_sequencer #(
  parameter int N         = 3,
  parameter int OSR1      = 2,
  parameter int OSR2      = 6,
  parameter int DEPTH     = 72,
  parameter int LUT_DELAY = 1,
  localparam int OSR         = OSR1 * OSR2,
  localparam int C1W         = (OSR1 > 1) ? $clog2(OSR1) : 1,
  localparam int C2W         = (OSR2 > 1) ? $clog2(OSR2) : 1,
  localparam int SW          = (N * OSR > 1) ? $clog2(N * OSR) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
`ifdef SEQ_FLUSH_EN
  input  logic           flush,
`endif
  output logic [C1W-1:0] osr_count1,
  output logic [C2W-1:0] osr_count2,
  output logic [SW-1:0]  in_sel,
  output logic           recurse_en,
  output logic           ds_en,
  output logic           compute_en,
  output logic           valid,
  output logic [1:0]     state
);

  localparam int DS_DEPTH    = (DEPTH + OSR - 1) / OSR;
  localparam int VALID_DELAY = DS_DEPTH + 2 + LUT_DELAY;
  localparam int DW          = $clog2(VALID_DELAY + 1);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] WARM = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [C1W-1:0] C1_LAST = C1W'(OSR1 - 1);
  localparam logic [C2W-1:0] C2_LAST = C2W'(OSR2 - 1);
  localparam logic [DW-1:0]  DS_SAT  = DW'(VALID_DELAY);
  localparam logic [DW-1:0]  DS_WARM = DW'(DS_DEPTH);

  logic [1:0]     rst_sync_q, rst_sync_d;
  logic [C1W-1:0] osr_count1_q, osr_count1_d;
  logic [C2W-1:0] osr_count2_q, osr_count2_d;
  logic [DW-1:0]  ds_count_q, ds_count_d;
  logic [1:0]     state_q, state_d;
  logic           recurse_en_q, recurse_en_d;
  logic           ds_en_q, ds_en_d;
  logic           accept, grp_end, frm_end;

  // Two-stage release synchronizer: samples are ignored until rst has been
  // seen high on two consecutive edges.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign accept     = in_valid && rst_sync_q[1];

  // With OSR1/OSR2 = 1 the LAST constants are 0, so the counters stay at 0
  // and every sample ends a group/frame.
  assign grp_end = (osr_count1_q == C1_LAST);
  assign frm_end = grp_end && (osr_count2_q == C2_LAST);

  always_comb begin
    osr_count1_d = osr_count1_q;
    osr_count2_d = osr_count2_q;
    ds_count_d   = ds_count_q;
    state_d      = state_q;
    recurse_en_d = 1'b0;
    ds_en_d      = 1'b0;

    if (accept) begin
      osr_count1_d = grp_end ? '0 : osr_count1_q + 1'b1;
      recurse_en_d = grp_end;
      if (grp_end) begin
        osr_count2_d = frm_end ? '0 : osr_count2_q + 1'b1;
      end
      if (frm_end) begin
        ds_en_d    = 1'b1;
        // Saturate so RUN is held forever without a wrap back into FILL.
        ds_count_d = (ds_count_q == DS_SAT) ? ds_count_q : ds_count_q + 1'b1;
        // State moves on the same edge that raises ds_en, so the new state is
        // visible alongside the pulse.
        case (state_q)
          FILL:    if (ds_count_d == DS_WARM) state_d = WARM;
          WARM:    if (ds_count_d == DS_SAT)  state_d = RUN;
          default: state_d = state_q;
        endcase
      end
    end

`ifdef SEQ_FLUSH_EN
    // Flush wins over a coincident sample, which is dropped.
    if (flush) begin
      osr_count1_d = '0;
      osr_count2_d = '0;
      ds_count_d   = '0;
      state_d      = FILL;
      recurse_en_d = 1'b0;
      ds_en_d      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q   <= '0;
      osr_count1_q <= '0;
      osr_count2_q <= '0;
      ds_count_q   <= '0;
      state_q      <= FILL;
      recurse_en_q <= 1'b0;
      ds_en_q      <= 1'b0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      osr_count1_q <= osr_count1_d;
      osr_count2_q <= osr_count2_d;
      ds_count_q   <= ds_count_d;
      state_q      <= state_d;
      recurse_en_q <= recurse_en_d;
      ds_en_q      <= ds_en_d;
    end
  end

  // Slot MSB index counts down from N*OSR-1 as the frame position advances.
  assign in_sel = SW'(N * (OSR - (32'(osr_count1_q) + OSR1 * 32'(osr_count2_q))) - 1);

  assign osr_count1 = osr_count1_q;
  assign osr_count2 = osr_count2_q;
  assign recurse_en = recurse_en_q;
  assign ds_en      = ds_en_q;
  assign state      = state_q;
  assign compute_en = (state_q != FILL);
  assign valid      = (state_q == RUN);

endmodule
